fpaddsub_sched: RTL and testbench

Round-robin scheduler that shares one `fpaddsub` instance between `NREQ` requesters, such as issue ports or FPU lanes. It accepts operand pairs over per-requester valid/ready handshakes and launches at most one operation per cycle into the combinational adder. Each result travels through a `LAT`-stage result pipeline, tagged with its requester, and lands in a one-entry response buffer per requester. Each requester may have exactly one operation in flight, which gives credit-based backpressure without stalling the shared pipe.

---
 rtl/fpaddsub_sched_pkg.sv | 21 ++
 rtl/fpaddsub.sv | 112 +++++++++++
 rtl/fpaddsub_sched_rr_arbiter.sv | 36 +++
 rtl/fpaddsub_sched.sv | 119 +++++++++++
 tb/tb_fpaddsub_sched.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fpaddsub_sched_pkg.sv
// rtl/fpaddsub_sched_pkg.sv - shared types and constants for the fpaddsub scheduler
// Purpose: result-pipeline stage record and the default-format special encodings.
//   stage_t : {valid, tag (requester index), data (adder result)}.
//   Field widths cover the largest supported configuration (NREQ<=16, N_BIT<=64);
//   users cast into and out of the fields.
package fpaddsub_sched_pkg;

  localparam int STAGE_TAG_W  = 4;
  localparam int STAGE_DATA_W = 64;

  typedef struct packed {
    logic                    valid;
    logic [STAGE_TAG_W-1:0]  tag;
    logic [STAGE_DATA_W-1:0] data;
  } stage_t;

  // Binary32 encodings: canonical quiet NaN and +infinity.
  localparam logic [31:0] P_NAN = 32'h7FC0_0000;
  localparam logic [31:0] P_INF = 32'h7F80_0000;

endpackage

// File: rtl/fpaddsub.sv
// rtl/fpaddsub.sv - combinational IEEE-754 style adder/subtractor
// Purpose: result = a + b (addnot_sub=1) or a - b (addnot_sub=0), round to nearest even,
//   denormals supported, NaN inputs and inf-inf give the canonical quiet NaN.
// Ports:
//   a, b       in  N_BIT  operands
//   addnot_sub in  1      1 = add, 0 = subtract
//   result     out N_BIT  rounded result
module fpaddsub
  import fpaddsub_sched_pkg::*;
#(
  parameter int N_BIT   = 32,
  parameter int EXP_BIT = 8,
  parameter int LOG_BIT = $clog2(N_BIT)
) (
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic             addnot_sub,
  output logic [N_BIT-1:0] result
);

  localparam int M  = N_BIT - EXP_BIT - 1;  // stored fraction bits
  localparam int W  = M + 4;                // hidden + fraction + guard/round/sticky
  localparam int EW = EXP_BIT + 2;          // working exponent with headroom
  localparam logic [EXP_BIT-1:0] EMAX = '1;
  localparam bit DEF_FMT = (N_BIT == 32) && (EXP_BIT == 8);
  localparam logic [N_BIT-1:0] QNAN = DEF_FMT ? N_BIT'(P_NAN)
                                              : {1'b0, EMAX, 1'b1, {(M-1){1'b0}}};
  localparam logic [N_BIT-1:0] QINF = DEF_FMT ? N_BIT'(P_INF)
                                              : {1'b0, EMAX, {M{1'b0}}};

  logic               sa, sb, sx, sy, eff_sub, lost, round_up;
  logic               a_nan, b_nan, a_inf, b_inf, a_big;
  logic [EXP_BIT-1:0] ea, eb, ex, ey, ex_eff, ey_eff, diff;
  logic [M-1:0]       ma, mb, mx, my;
  logic [W-1:0]       fx, fy, fy_sh, fy_al, norm;
  logic [W:0]         sum;
  logic [LOG_BIT-1:0] lz;
  logic [EW-1:0]      e, shift;
  logic [M+1:0]       mant;

  always_comb begin
    sa = a[N_BIT-1];
    ea = a[N_BIT-2:M];
    ma = a[M-1:0];
    sb = b[N_BIT-1] ^ ~addnot_sub;
    eb = b[N_BIT-2:M];
    mb = b[M-1:0];
    a_nan = (ea == EMAX) && (ma != '0);
    b_nan = (eb == EMAX) && (mb != '0);
    a_inf = (ea == EMAX) && (ma == '0);
    b_inf = (eb == EMAX) && (mb == '0);

    // x is the larger magnitude so the aligned difference is never negative.
    a_big = {ea, ma} >= {eb, mb};
    {sx, ex, mx} = a_big ? {sa, ea, ma} : {sb, eb, mb};
    {sy, ey, my} = a_big ? {sb, eb, mb} : {sa, ea, ma};
    ex_eff = (ex == '0) ? EXP_BIT'(1) : ex;
    ey_eff = (ey == '0) ? EXP_BIT'(1) : ey;
    diff   = ex_eff - ey_eff;
    fx     = {(ex != '0), mx, 3'b000};
    fy     = {(ey != '0), my, 3'b000};

    // Bits shifted out of y collapse into the sticky position.
    fy_sh = fy >> diff;
    lost  = (fy_sh << diff) != fy;
    fy_al = {fy_sh[W-1:1], fy_sh[0] | lost};

    eff_sub = sx ^ sy;
    sum = eff_sub ? ({1'b0, fx} - {1'b0, fy_al}) : ({1'b0, fx} + {1'b0, fy_al});

    lz = LOG_BIT'(W);
    for (int i = 0; i < W; i++) begin
      if (sum[i]) lz = LOG_BIT'(W - 1 - i);
    end

    e     = EW'(ex_eff);
    shift = '0;
    if (sum[W]) begin
      norm = {sum[W:2], sum[1] | sum[0]};
      e    = e + EW'(1);
    end else begin
      // Stop normalising at exponent 1; what remains is a denormal.
      shift = (EW'(lz) < e - EW'(1)) ? EW'(lz) : e - EW'(1);
      norm  = sum[W-1:0] << shift;
      e     = e - shift;
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant     = {1'b0, norm[W-1:3]} + (M+2)'(round_up);
    if (mant[M+1]) begin
      mant = mant >> 1;
      e    = e + EW'(1);
    end

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      result = QNAN;
    end else if (a_inf) begin
      result = QINF | {sa, {(N_BIT-1){1'b0}}};
    end else if (b_inf) begin
      result = QINF | {sb, {(N_BIT-1){1'b0}}};
    end else if (sum == '0) begin
      // Exact cancellation gives +0 unless both addends were -0.
      result = {sx & sy, {(N_BIT-1){1'b0}}};
    end else if (e >= EW'(EMAX)) begin
      result = QINF | {sx, {(N_BIT-1){1'b0}}};
    end else begin
      // A clear hidden bit after rounding means the result stayed denormal.
      result = {sx, (mant[M] ? e[EXP_BIT-1:0] : {EXP_BIT{1'b0}}), mant[M-1:0]};
    end
  end

endmodule

// File: rtl/fpaddsub_sched_rr_arbiter.sv
// rtl/fpaddsub_sched_rr_arbiter.sv - rotating-priority arbiter
// Purpose: grant the first eligible index scanning ptr, ptr+1, ..., wrapping at N.
// Ports:
//   elig      in  N   eligible requesters
//   ptr       in  IW  index with highest priority this cycle
//   grant     out N   one-hot grant (zero when nothing is eligible)
//   grant_idx out IW  encoded grant (zero when nothing is eligible)
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && elig[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpaddsub_sched.sv
// rtl/fpaddsub_sched.sv - round-robin sharing of one fpaddsub between NREQ requesters
// Purpose: one launch per cycle into a shared adder, LAT-cycle tagged result path,
//   one-entry response buffer and one outstanding operation per requester.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   NREQ       operation handshake (ready is the combinational grant)
//   req_a, req_b      NREQ*N_BIT operands
//   req_addnot_sub    NREQ       1 = add, 0 = subtract
//   rsp_valid/ready   NREQ       response handshake
//   rsp_data          NREQ*N_BIT buffered results
//   busy              NREQ       requester has an operation outstanding
module fpaddsub_sched
  import fpaddsub_sched_pkg::*;
#(
  parameter int N_BIT   = 32,
  parameter int EXP_BIT = 8,
  parameter int NREQ    = 4,
  parameter int LAT     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][N_BIT-1:0] req_a,
  input  logic [NREQ-1:0][N_BIT-1:0] req_b,
  input  logic [NREQ-1:0]            req_addnot_sub,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [NREQ-1:0][N_BIT-1:0] rsp_data,
  output logic [NREQ-1:0]            busy
);

  localparam int TAG_W = $clog2(NREQ);

  logic [NREQ-1:0]  elig, grant, rsp_fire;
  logic [TAG_W-1:0] ptr, grant_idx;
  logic             grant_any;
  logic [N_BIT-1:0] add_result;
  stage_t           launch, tail;

  assign elig      = req_valid & ~busy;
  assign grant_any = |grant;
  assign req_ready = grant & {NREQ{rst_n}};
  assign rsp_fire  = rsp_valid & rsp_ready;

  rr_arbiter #(.N(NREQ)) u_arb (
    .elig      (elig),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  fpaddsub #(.N_BIT(N_BIT), .EXP_BIT(EXP_BIT)) u_add (
    .a          (req_a[grant_idx]),
    .b          (req_b[grant_idx]),
    .addnot_sub (req_addnot_sub[grant_idx]),
    .result     (add_result)
  );

  always_comb begin
    launch       = '0;
    launch.valid = grant_any;
    launch.tag   = STAGE_TAG_W'(grant_idx);
    launch.data  = STAGE_DATA_W'(add_result);
  end

  // The response buffers are the last of the LAT stages, so only LAT-1
  // free-running registers sit between the adder and the buffers.
  if (LAT == 1) begin : g_no_pipe
    assign tail = launch;
  end else begin : g_pipe
    stage_t pipe [LAT-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < LAT - 1; s++) pipe[s] <= '0;
      end else begin
        pipe[0] <= launch;
        for (int s = 1; s < LAT - 1; s++) pipe[s] <= pipe[s-1];
      end
    end
    assign tail = pipe[LAT-2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      busy      <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (grant_any) begin
        ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + TAG_W'(1);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          busy[i] <= 1'b1;
        end else if (rsp_fire[i]) begin
          busy[i] <= 1'b0;
        end
        // busy keeps a write and a handshake of the same index apart.
        if (tail.valid && int'(tail.tag) == i) begin
          rsp_valid[i] <= 1'b1;
          rsp_data[i]  <= N_BIT'(tail.data);
        end else if (rsp_fire[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst_n && tail.valid && int'(tail.tag) == i) begin
        assert (!rsp_valid[i]);
      end
    end
  end

endmodule

// File: tb/tb_fpaddsub_sched.sv
// tb/tb_fpaddsub_sched.sv - directed self-checking bench for fpaddsub_sched
module tb_fpaddsub_sched;
  import fpaddsub_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int N_BIT = 32;
  localparam int LAT   = 2;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NREQ-1:0]            req_valid = '0;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][N_BIT-1:0] req_a = '0;
  logic [NREQ-1:0][N_BIT-1:0] req_b = '0;
  logic [NREQ-1:0]            req_addnot_sub = '0;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ-1:0]            rsp_ready = '0;
  logic [NREQ-1:0][N_BIT-1:0] rsp_data;
  logic [NREQ-1:0]            busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpaddsub_sched #(.N_BIT(N_BIT), .EXP_BIT(8), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_addnot_sub (req_addnot_sub),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic single_op(input string tag, input int idx, input logic [31:0] a,
                           input logic [31:0] b, input logic add, input logic [31:0] exp);
    req_a[idx] = a;
    req_b[idx] = b;
    req_addnot_sub[idx] = add;
    req_valid = NREQ'(1 << idx);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
    step();
    req_valid = '0;
    #1;
    check({tag, "_busy"}, 32'(busy), 32'(1 << idx));
    check({tag, "_early"}, 32'(rsp_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(rsp_valid), 32'(1 << idx));
    check({tag, "_data"}, rsp_data[idx], exp);
    step();
    check({tag, "_done"}, 32'({busy, rsp_valid}), 32'd0);
  endtask

  logic [31:0] rr_exp [NREQ];
  int          bp_g [13];

  initial begin
    rr_exp = '{32'h4040_0000, 32'h3F80_0000, P_NAN, P_INF};
    bp_g   = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3, 0, 1, 2};

    // Reset state, with every requester asking.
    req_valid = '1;
    step();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data0", rsp_data[0], 32'd0);
    req_valid = '0;
    step();
    rst_n = 1'b1;

    // Round robin, all valid, responses always taken; includes special values.
    req_a = {P_INF, P_INF, 32'h4000_0000, 32'h3F80_0000};
    req_b = {32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h4000_0000};
    req_addnot_sub = 4'b1101;
    rsp_ready = '1;
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("rr_grant_c%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= LAT) begin
        check($sformatf("rr_rsp_valid_c%0d", c), 32'(rsp_valid), 32'(1 << ((c - LAT) % 4)));
        check($sformatf("rr_rsp_data_c%0d", c), rsp_data[(c - LAT) % 4], rr_exp[(c - LAT) % 4]);
      end else begin
        check($sformatf("rr_rsp_valid_c%0d", c), 32'(rsp_valid), 32'd0);
      end
      step();
    end

    // Backpressure on requester 2 for ten cycles.
    do_reset();
    rsp_ready = 4'b1011;
    req_valid = '1;
    for (int c = 0; c < 13; c++) begin
      if (c == 10) rsp_ready = '1;
      #1;
      check($sformatf("bp_grant_c%0d", c), 32'(req_ready), 32'(1 << bp_g[c]));
      if (c >= 4 && c <= 10) begin
        check($sformatf("bp_hold_valid_c%0d", c), 32'(rsp_valid[2]), 32'd1);
        check($sformatf("bp_hold_data_c%0d", c), rsp_data[2], P_NAN);
      end
      if (c == 9) check("bp_busy_c9", 32'(busy), 32'b0111);
      step();
    end

    // Reset one cycle after two grants.
    do_reset();
    rsp_ready = '1;
    req_valid = 4'b0011;
    #1;
    check("mr_grant0", 32'(req_ready), 32'b0001);
    step();
    check("mr_grant1", 32'(req_ready), 32'b0010);
    step();
    check("mr_pre_valid", 32'(rsp_valid), 32'b0001);
    rst_n = 1'b0;
    #1;
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("mr_stale_c%0d", c), 32'({busy, rsp_valid}), 32'd0);
      step();
    end
    req_valid = 4'b1010;
    #1;
    check("mr_first_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();
    step();

    // Single operations with exact latency checks.
    do_reset();
    rsp_ready = '1;
    step();
    step();
    step();
    step();
    single_op("one_plus_two", 0, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h4040_0000);
    single_op("cancel", 1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h0000_0000);
    single_op("denorm", 2, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0002);
    single_op("mixed", 3, 32'h3FC0_0000, 32'h4010_0000, 1'b1, 32'h4070_0000);
    single_op("tie_even", 0, 32'h3F80_0000, 32'h3380_0000, 1'b1, 32'h3F80_0000);
    single_op("tie_odd", 1, 32'h3F80_0001, 32'h3380_0000, 1'b1, 32'h3F80_0002);
    single_op("inf_minus_inf", 2, P_INF, P_INF, 1'b0, P_NAN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
